program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h0000, the byte address of the first instruction written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256, the maximum number of 16-bit instruction words accepted per load.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock).
REQ-005 Port start  input  1  single-cycle request to begin a load.
REQ-006 Port in_valid  input  1  instruction word present on in_data.
REQ-007 Port in_data  input  16  instruction word.
REQ-008 Port in_last  input  1  marks the final word of the program.
REQ-009 Port in_ready  output  1  loader can accept a word this cycle.
REQ-010 Port imem_we  output  1  instruction memory write strobe.
REQ-011 Port imem_addr  output  16  instruction memory byte address.
REQ-012 Port imem_wdata  output  16  instruction memory write data.
REQ-013 Port cpu_reset  output  1  active-high reset driven to the CPU.
REQ-014 Port cpu_halt  input  1  CPU has executed HALT.
REQ-015 Port busy  output  1  state is LOAD, RELEASE or RUN.
REQ-016 Port done  output  1  CPU halted after a completed load.
REQ-017 Port overflow  output  1  program exceeded MAX_WORDS; sticky.
REQ-018 Port word_count  output  16  words written in the current load.
REQ-019 Port cycle_count  output  32  CPU clock cycles from release to halt.
REQ-020 Port checksum  output  16  modulo-2^16 sum of loaded words.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RELEASE, RUN, DONE, ERROR.
REQ-022 IDLE: cpu_reset=1, in_ready=0; start=1 -> LOAD, clearing word_count, cycle_count, checksum and setting the write pointer to BASE_ADDR.
REQ-023 LOAD: in_ready=1; a beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-024 Each accepted beat SHALL produce, on the following cycle, imem_we=1 for exactly one cycle with imem_addr = pointer and imem_wdata = in_data (one-cycle registered latency).
REQ-025 Each accepted beat SHALL advance the pointer by 2 (wrapping modulo 2^16) and increment word_count by 1.
REQ-026 An accepted beat with in_last=1 SHALL move LOAD -> RELEASE; in_ready SHALL be 0 from the next cycle.
REQ-027 An accepted beat without in_last when word_count already equals MAX_WORDS-1 SHALL write that word, set overflow=1 and move to ERROR; a last beat at that count is legal.
REQ-028 RELEASE SHALL last exactly one cycle with cpu_reset=1 so the final write lands before the CPU starts, then move to RUN.
REQ-029 RUN: cpu_reset=0; cycle_count increments by 1 every cycle, saturating at 32'hFFFFFFFF.
REQ-030 cpu_halt=1 in RUN SHALL move to DONE on the same edge; cycle_count excludes that edge and freezes.
REQ-031 DONE: done=1, cpu_reset=0 (CPU state remains observable); start=1 -> LOAD with cpu_reset=1 from the next cycle.
REQ-032 ERROR: cpu_reset=1, in_ready=0, overflow=1; exited only by reset.
REQ-033 start SHALL be ignored in LOAD, RELEASE, RUN, ERROR; in_valid SHALL be ignored outside LOAD; cpu_halt SHALL be ignored outside RUN.

Reset
REQ-034 On reset=0 at a rising edge: state=IDLE, cpu_reset=1, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, overflow=0, word_count=0, cycle_count=0, checksum=0.
REQ-035 Reset during LOAD SHALL suppress any pending imem_we on the next cycle.

Configuration
REQ-036 With macro PROGRAM_LOADER_CHECKSUM_EN defined, checksum SHALL add each accepted word modulo 2^16 in the cycle it is written; without it, checksum SHALL be constant 16'h0000 and no adder is synthesized.

Verification
REQ-037 Load 3 words 16'h1111, 16'h2222, 16'h3333 (last on third) -> writes at 0x0000/0x0002/0x0004, word_count=3, cpu_reset falls 2 cycles after the last accept, checksum=16'h6666 with macro.
REQ-038 in_valid toggled 1,0,1,0 during 2-word load -> exactly 2 imem_we pulses, no duplicate or missing addresses.
REQ-039 MAX_WORDS=4, 5 beats without in_last -> 4 writes, overflow=1, state ERROR, cpu_reset stays 1 until reset.
REQ-040 cpu_halt asserted 10 cycles after RUN entry -> done=1, cycle_count=10, frozen thereafter.
REQ-041 reset=0 one cycle after an accepted beat in LOAD -> no imem_we, all outputs at reset values next cycle.
REQ-042 start in DONE with a new 1-word program -> cpu_reset=1, word_count and cycle_count cleared, write at BASE_ADDR.

Source files
------------

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then releases and times the CPU until it halts.
// Optional load checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_reset,
  input  logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic [31:0] cycle_count,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE, S_ERROR} state_t;

  localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] wc_q, wc_d;
  logic [31:0] cc_q, cc_d;
  logic        ovf_q, ovf_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        load_start;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wc_d       = wc_q;
    cc_d       = cc_q;
    ovf_d      = ovf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_start = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = S_LOAD;
          ptr_d      = BASE_ADDR;
          wc_d       = 16'h0000;
          cc_d       = 32'h0000_0000;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          accept  = 1'b1;
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + 16'd2;
          wc_d    = wc_q + 16'd1;
          // The word that overflows is still written before the block locks up.
          if (in_last) begin
            state_d = S_RELEASE;
          end else if (wc_q == LAST_IDX) begin
            ovf_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        if (cpu_halt) state_d = S_DONE;
        else if (cc_q != 32'hFFFF_FFFF) cc_d = cc_q + 32'd1;
      end
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_ADDR;
      wc_q    <= 16'h0000;
      cc_q    <= 32'h0000_0000;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      cc_q    <= cc_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    if (load_start)  cs_d = 16'h0000;
    else if (accept) cs_d = cs_q + in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) cs_q <= 16'h0000;
    else        cs_q <= cs_d;
  end

  assign checksum = cs_q;
`else
  assign checksum = 16'h0000;
`endif

  assign in_ready    = (state_q == S_LOAD);
  // CPU is held in reset through RELEASE so the final write lands first.
  assign cpu_reset   = !((state_q == S_RUN) || (state_q == S_DONE));
  assign busy        = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign overflow    = ovf_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = wc_q;
  assign cycle_count = cc_q;

endmodule
